axi4lite_slave_mem: RTL and testbench
=====================================

Name: axi4lite_slave_mem

Overview:
Parametrised AXI4-Lite memory slave and the next generation of the team's fixed 8-word slave.
- Supports configurable data width, memory depth and base address.
- Accepts the AW and W channels independently, in either order.
- Fully back-pressures every channel.
- Returns OKAY or DECERR per transaction.
- Sits behind the interconnect as a generic register/scratch memory target for VIP master testing.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
ADDRESS_WIDTH, 32, byte address width.
MEM_DEPTH, 8, number of DATA_WIDTH-bit words; must be a power of 2 and at least 2.
BASE_ADDR, 0, byte address of word 0; must be aligned to MEM_DEPTH*DATA_WIDTH/8.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
awaddr  in  ADDRESS_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDRESS_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset:
  - All outputs are 0; both holding registers are empty.
  - All memory words clear to 0.
  - Reset asserted mid-transaction aborts it. No write commits from a partially captured pair.
- Address decode:
  - off = addr - BASE_ADDR.
  - In range when addr >= BASE_ADDR and off < MEM_DEPTH*DATA_WIDTH/8.
  - idx = off >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
- Write path:
  - awready = 1 while the AW holding register is empty. The AW handshake captures awaddr.
  - wready = 1 while the W holding register is empty. The W handshake captures wdata and wstrb.
  - Either channel may arrive first, or both may arrive in the same cycle.
  - Commit happens in the first cycle where both registers are full and bvalid = 0. That cycle is therefore at least one cycle after the later handshake.
  - On commit:
    - In range: only bytes with wstrb[i] = 1 are written; bresp = 2'b00.
    - Out of range: memory is unchanged; bresp = 2'b11.
    - Both holding registers empty on the commit edge.
    - bvalid rises on the commit edge.
  - bvalid and bresp hold stable until bready is sampled high, then bvalid drops. bresp returns to 0.
  - A new AW/W pair may be captured while bvalid is pending. Its commit waits until bvalid clears.
  - Maximum one outstanding write response.
  - Back-to-back throughput: one write per 2 cycles when bready is held high.
- Read path:
  - arready = !rvalid || rready, which allows back-to-back reads at 1 per cycle.
  - On the AR handshake edge, rdata, rresp and rvalid are registered; rvalid = 1 at the next cycle.
    - In range: rdata = mem[idx] before any write committing on the same edge (read-first); rresp = 2'b00.
    - Out of range: rdata = 0; rresp = 2'b11.
  - rdata, rresp and rvalid hold stable while rvalid && !rready.
  - rvalid drops after the rready handshake unless a new AR handshake occurs on the same edge.
- Channels are independent; read and write proceed concurrently.
- Valid-to-ready dependence: no ready depends combinationally on the same channel's valid. arready does depend on rready.
- Response codes 2'b01 and 2'b10 are never generated.

Test Plan:
- Reset then read every word with araddr = BASE_ADDR+4k -> rdata = 0, rresp = 0, rvalid exactly one cycle after each AR handshake.
- W (wdata = 32'hDEADBEEF, wstrb = 4'hF) two cycles before AW (awaddr = BASE_ADDR+8) -> bvalid, bresp = 0; a later read of +8 returns 32'hDEADBEEF.
- Partial strobe: word preloaded with 32'h11223344, then a write of 32'hAABBCCDD with wstrb = 4'b0101 -> read returns 32'h11BB33DD.
- Out-of-range write at BASE_ADDR + MEM_DEPTH*4, and a read below BASE_ADDR -> bresp = 2'b11, rresp = 2'b11, rdata = 0, memory unchanged.
- Back-pressure: bready and rready held low for 5 cycles -> bvalid, rvalid, bresp, rdata and rresp stable; arready = 0; a second write pair is captured but not committed until bready rises.
- Simultaneous write of 32'h5 and read of the same address on the commit edge -> read returns the old value; the next read returns 32'h5. Assert rst_n mid-transaction -> all outputs 0 and memory cleared.

Source files
------------

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite memory slave: MEM_DEPTH words of DATA_WIDTH bits mapped at BASE_ADDR.
// AW and W are captured into independent holding registers, in either order.
// A write commits once both are held and no write response is pending.
// Reads are registered with a single-cycle latency and can be issued back to back.
// Addresses outside the window return DECERR. Out-of-window reads return zero data,
// and out-of-window writes leave memory unchanged.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel
module axi4lite_slave_mem #(
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              MEM_DEPTH     = 8,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDRESS_WIDTH-1:0]   araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(MEM_DEPTH * STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write-side state
    logic                      aw_full_q, aw_full_d;
    logic [ADDRESS_WIDTH-1:0]  aw_addr_q, aw_addr_d;
    logic                      w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0]     w_data_q,  w_data_d;
    logic [STRB_W-1:0]         w_strb_q,  w_strb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q,  wready_d;
    logic                      bvalid_q,  bvalid_d;
    logic [1:0]                bresp_q,   bresp_d;
    logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]     mem_d [MEM_DEPTH];

    // Read-side state
    logic                      rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0]     rdata_q,   rdata_d;
    logic [1:0]                rresp_q,   rresp_d;
    // Holds arready low while in reset; arready is the only combinational ready.
    logic                      live_q,    live_d;

    logic [ADDRESS_WIDTH-1:0]  wr_off, rd_off;
    logic                      wr_hit, rd_hit;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      commit;
    logic                      ar_hs;

    // Write capture, commit and response
    always_comb begin
        wr_off    = aw_addr_q - BASE_ADDR;
        wr_hit    = (aw_addr_q >= BASE_ADDR) && (wr_off < MEM_BYTES);
        wr_idx    = wr_off[ADDR_LSB +: IDX_W];
        commit    = aw_full_q && w_full_q && !bvalid_q;

        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_d     = mem_q;

        if (awvalid && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (wvalid && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
            bresp_d  = RESP_OKAY;
        end
        // commit implies bvalid_q == 0, so it never collides with the response handshake
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_hit ? RESP_OKAY : RESP_DECERR;
            if (wr_hit) begin
                for (int b = 0; b < int'(STRB_W); b++) begin
                    if (w_strb_q[b]) begin
                        mem_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end

        // Ready reflects next-cycle emptiness so it is a flop, not a path from valid
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
    end

    // Read request and data hold
    always_comb begin
        rd_off   = araddr - BASE_ADDR;
        rd_hit   = (araddr >= BASE_ADDR) && (rd_off < MEM_BYTES);
        rd_idx   = rd_off[ADDR_LSB +: IDX_W];
        ar_hs    = arvalid && arready;
        live_d   = 1'b1;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_hs) begin
            // mem_q is the pre-commit value, giving read-first ordering
            rvalid_d = 1'b1;
            rdata_d  = rd_hit ? mem_q[rd_idx] : '0;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_DECERR;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            live_q    <= 1'b0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            live_q    <= live_d;
            mem_q     <= mem_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign arready = live_q && (!rvalid_q || rready);

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Directed bench for axi4lite_slave_mem (32-bit data, 8 words, base 0x1000).
module tb_axi4lite_slave_mem;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    axi4lite_slave_mem #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .MEM_DEPTH    (8),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write with optional per-channel start delays; ok=0 on any expired bound
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic ok);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int c = 0;
        ok = 1'b1;
        resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
        while (!(aw_done && w_done) && c < 50) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) ok = 1'b0;
        c = 0;
        while (!bvalid && c < 50) begin
            tick();
            c++;
        end
        if (!bvalid) ok = 1'b0;
        else begin
            resp = bresp;
            tick();
        end
    endtask

    // Read; ok=0 if arready never comes or rvalid is not set exactly one cycle after the handshake
    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output logic ok);
        int c = 0;
        ok = 1'b1;
        d = 'x;
        resp = 2'bxx;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && c < 50) begin
            tick();
            c++;
        end
        if (!arready) begin
            ok = 1'b0;
            arvalid = 1'b0;
            return;
        end
        tick();
        arvalid = 1'b0;
        ok = rvalid;
        d = rdata;
        resp = rresp;
        tick();
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        ok;
    int          cnt;

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        vecs[0]  = '{1'b1, BASE + 32'h04, 32'h1122_3344, 4'hF, 2'b00, 32'h0, "wr_preload"};
        vecs[1]  = '{1'b1, BASE + 32'h04, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0, "wr_strb0101"};
        vecs[2]  = '{1'b0, BASE + 32'h04, 32'h0, 4'h0, 2'b00, 32'h11BB_33DD, "rd_strb0101"};
        vecs[3]  = '{1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 2'b11, 32'h0, "wr_above"};
        vecs[4]  = '{1'b0, BASE - 32'h04, 32'h0, 4'h0, 2'b11, 32'h0, "rd_below"};
        vecs[5]  = '{1'b0, BASE + 32'h00, 32'h0, 4'h0, 2'b00, 32'h0, "rd_w0_untouched"};
        vecs[6]  = '{1'b1, BASE + 32'h1E, 32'h0102_0304, 4'hC, 2'b00, 32'h0, "wr_unaligned"};
        vecs[7]  = '{1'b0, BASE + 32'h1C, 32'h0, 4'h0, 2'b00, 32'h0102_0000, "rd_w7"};
        vecs[8]  = '{1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'h0, 2'b00, 32'h0, "wr_nostrb"};
        vecs[9]  = '{1'b0, BASE + 32'h10, 32'h0, 4'h0, 2'b00, 32'h0, "rd_nostrb"};
        vecs[10] = '{1'b0, BASE + 32'h40, 32'h0, 4'h0, 2'b11, 32'h0, "rd_above"};
        vecs[11] = '{1'b1, 32'h0, 32'h1234_5678, 4'hF, 2'b11, 32'h0, "wr_below"};
        vecs[12] = '{1'b0, BASE + 32'h1C, 32'h0, 4'h0, 2'b00, 32'h0102_0000, "rd_w7_again"};

        // Reset values
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata_resp", {rdata, rresp, bresp}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Every word reads zero after reset
        for (int k = 0; k < 8; k++) begin
            do_read(BASE + 32'(4 * k), rd, rs, ok);
            chk($sformatf("sweep%0d_lat", k), ok, 1);
            chk($sformatf("sweep%0d_data", k), rd, 0);
            chk($sformatf("sweep%0d_resp", k), rs, 0);
        end

        // W two cycles ahead of AW
        do_write(BASE + 32'h08, 32'hDEAD_BEEF, 4'hF, 2, 0, rs, ok);
        chk("wfirst_ok", ok, 1);
        chk("wfirst_resp", rs, 0);
        // AW two cycles ahead of W
        do_write(BASE + 32'h18, 32'h0BAD_CAFE, 4'hF, 0, 2, rs, ok);
        chk("awfirst_ok", ok, 1);
        chk("awfirst_resp", rs, 0);
        do_read(BASE + 32'h08, rd, rs, ok);
        chk("wfirst_rd", {ok, rs, rd}, {1'b1, 2'b00, 32'hDEAD_BEEF});
        do_read(BASE + 32'h18, rd, rs, ok);
        chk("awfirst_rd", {ok, rs, rd}, {1'b1, 2'b00, 32'h0BAD_CAFE});

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, rs, ok);
                chk({vecs[i].name, "_ok"}, ok, 1);
                chk({vecs[i].name, "_bresp"}, rs, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, rd, rs, ok);
                chk({vecs[i].name, "_ok"}, ok, 1);
                chk({vecs[i].name, "_rresp"}, rs, vecs[i].exp_resp);
                chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_data);
            end
        end

        // Back-pressure on B and R with a second write pair captured behind the pending response
        bready = 1'b0; rready = 1'b0;
        awaddr = BASE + 32'h0C; wdata = 32'h55; wstrb = 4'hF;
        chk("bp_awready_idle", {awready, wready}, 2'b11);
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE + 32'h04; arvalid = 1'b1;
        chk("bp_arready_idle", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("bp_first_commit", {bvalid, bresp, rvalid, rresp, rdata}, {1'b1, 2'b00, 1'b1, 2'b00, 32'h11BB_33DD});
        awaddr = BASE + 32'h0C; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1;
        chk("bp_second_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE; arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_b", c), {bvalid, bresp}, {1'b1, 2'b00});
            chk($sformatf("bp%0d_r", c), {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'h11BB_33DD});
            chk($sformatf("bp%0d_ready", c), {arready, awready, wready}, 3'b000);
        end
        arvalid = 1'b0;
        bready = 1'b1;
        tick();
        chk("bp_b_drop", bvalid, 0);
        tick();
        chk("bp_second_commit", {bvalid, bresp}, {1'b1, 2'b00});
        tick();
        chk("bp_second_drop", bvalid, 0);
        rready = 1'b1;
        tick();
        chk("bp_r_drop", rvalid, 0);
        do_read(BASE + 32'h0C, rd, rs, ok);
        chk("bp_second_data", {ok, rs, rd}, {1'b1, 2'b00, 32'h66});

        // Back-to-back reads at one per cycle
        araddr = BASE + 32'h08; arvalid = 1'b1; rready = 1'b1;
        tick();
        araddr = BASE + 32'h0C;
        chk("b2b_first", {rvalid, rdata, arready}, {1'b1, 32'hDEAD_BEEF, 1'b1});
        tick();
        arvalid = 1'b0;
        chk("b2b_second", {rvalid, rdata}, {1'b1, 32'h66});
        tick();
        chk("b2b_idle", rvalid, 0);

        // Read and commit of the same word on one edge: read sees the old value
        awaddr = BASE + 32'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE + 32'h0C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("same_edge_bvalid", {bvalid, bresp}, {1'b1, 2'b00});
        chk("same_edge_old", {rvalid, rdata}, {1'b1, 32'h66});
        tick();
        do_read(BASE + 32'h0C, rd, rs, ok);
        chk("same_edge_new", {ok, rs, rd}, {1'b1, 2'b00, 32'h5});

        // Reset with only AW captured: nothing may commit from the half pair
        awaddr = BASE + 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        cnt = 0;
        while (!wready && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("mid_rst_wready", wready, 1);
        tick();
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_rst_no_commit%0d", c), bvalid, 0);
        end
        awaddr = BASE + 32'h14; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        cnt = 0;
        while (!bvalid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("mid_rst_commit", {bvalid, bresp}, {1'b1, 2'b00});
        tick();
        do_read(BASE + 32'h08, rd, rs, ok);
        chk("mid_rst_cleared", {ok, rs, rd}, {1'b1, 2'b00, 32'h0});
        do_read(BASE + 32'h10, rd, rs, ok);
        chk("mid_rst_w4", {ok, rs, rd}, {1'b1, 2'b00, 32'h0});
        do_read(BASE + 32'h14, rd, rs, ok);
        chk("mid_rst_w5", {ok, rs, rd}, {1'b1, 2'b00, 32'h77});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
